ysyx_25020047_ifu_fetch: RTL and testbench
==========================================

# ysyx_25020047_ifu_fetch

Multi-cycle instruction fetch unit that replaces the single-cycle combinational IFU in the NPC core. It holds the architectural PC, fetches each instruction over a valid/ready read channel to instruction memory, and presents it to the IDU through a valid/ready handshake. It then waits for the next PC (dnpc) from the WBU before starting the next fetch. It also counts delivered instructions for performance tracing.

## Interface
- RESET_PC, 32'h8000_0000, PC value loaded on reset
- clk  in  1  core clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- ifu_arvalid  out  1  read request valid
- ifu_araddr  out  32  read address (equals pc)
- ifu_arready  in  1  memory accepts request
- ifu_rvalid  in  1  read data valid
- ifu_rdata  in  32  instruction word
- ifu_rresp  in  2  response code, 2'b00 = OKAY, any other value = error
- ifu_rready  out  1  unit accepts read data
- out_valid  out  1  instruction available to IDU
- out_ready  in  1  IDU accepts instruction
- out_inst  out  32  instruction word
- out_pc  out  32  PC of out_inst
- out_err  out  1  fetch fault (bus error or misaligned PC)
- wb_valid  in  1  WBU presents next PC
- wb_dnpc  in  32  next PC
- pc  out  32  current architectural PC
- fetch_cnt  out  32  instructions delivered to IDU

## Operation
- States: IDLE, REQ, WAIT, HOLD, EXEC.
- IDLE: entered only by reset. Moves unconditionally to REQ on the next edge.
- REQ: ifu_arvalid=1, ifu_araddr=pc. ifu_arvalid and ifu_araddr stay stable until ifu_arready. When ifu_arvalid & ifu_arready → WAIT.
- WAIT: ifu_rready=1. When ifu_rvalid: latch out_inst=ifu_rdata and out_err=(ifu_rresp!=0), then → HOLD.
- HOLD: out_valid=1. out_inst, out_pc and out_err stay stable until out_ready. When out_valid & out_ready: fetch_cnt += 1, then → EXEC.
- EXEC: wait for wb_valid. On wb_valid, pc ← wb_dnpc.
  - If wb_dnpc[1:0]==0 → REQ.
  - Otherwise (misaligned) → HOLD directly, with out_inst=0, out_err=1, out_pc=wb_dnpc. No bus request is issued.
- wb_valid is ignored in every state except EXEC.
- ifu_rvalid is ignored outside WAIT, since ifu_rready=0 there.
- out_pc always equals pc while out_valid=1.
- An error fetch (out_err=1) is delivered and counted like any other. The trap decision belongs to the IDU/EXU.
- fetch_cnt is unsigned 32-bit and wraps from 32'hFFFF_FFFF to 0.

## Timing
- While rst=0:
  - state=IDLE, pc=RESET_PC, fetch_cnt=0, out_inst=0, out_err=0.
  - ifu_arvalid=ifu_rready=out_valid=0.
  - ifu_araddr=out_pc=RESET_PC.
- First rising edge after release: IDLE→REQ. ifu_arvalid goes high in cycle 1 after release.
- Best-case latency, from ifu_arvalid rising to out_valid rising, is 2 cycles. This assumes ifu_arready is high in the REQ cycle and ifu_rvalid is high in the first WAIT cycle.
- Memory stalls on arready or rvalid extend REQ or WAIT indefinitely. There is no timeout.
- out_ready=0 holds HOLD indefinitely with outputs unchanged.
- EXEC→REQ takes 1 edge, so ifu_arvalid rises in the cycle after wb_valid.
- pc updates on the same edge that leaves EXEC.
- Asynchronous reset asserted in any state (including mid-WAIT with a response outstanding): immediately returns to reset values. A stale ifu_rvalid arriving after reset release lands in IDLE or REQ and is ignored.
- out_valid, ifu_arvalid and ifu_rready are decoded from the registered state. They have no combinational path from any input.

## Test plan
- Reset release, ifu_arready=1, ifu_rvalid=1 one cycle after the request, ifu_rdata=32'h00000413, out_ready=1 → ifu_araddr=32'h8000_0000 in cycle 1; out_valid in cycle 3 with out_inst=32'h00000413, out_pc=32'h8000_0000, out_err=0; fetch_cnt=1.
- ifu_arready held 0 for 5 cycles, then 1 → ifu_arvalid=1 and ifu_araddr stable for all 6 cycles; exactly one request is accepted.
- out_ready=0 for 4 cycles during HOLD, with wb_valid pulsed meanwhile → outputs frozen, pc unchanged, wb_valid ignored; the handshake completes on the cycle out_ready rises.
- In EXEC, wb_valid=1 with wb_dnpc=32'h8000_0010 → next request has ifu_araddr=32'h8000_0010. With wb_dnpc=32'h8000_0012 instead → no ifu_arvalid; out_valid=1, out_err=1, out_inst=0, out_pc=32'h8000_0012.
- Response with ifu_rresp=2'b10 → out_err=1; fetch_cnt still increments on delivery.
- rst asserted in WAIT, and ifu_rvalid=1 arrives 1 cycle after release → pc=RESET_PC, the stale response is ignored, and a fresh request goes to 32'h8000_0000. Separately, preload fetch_cnt to 32'hFFFF_FFFF by forcing it → it wraps to 0 on the next delivery.

Source files
------------

// File: rtl/ysyx_25020047_ifu_fetch.sv
// ysyx_25020047_ifu_fetch
//
// Multi-cycle instruction fetch unit. It holds the architectural PC and
// fetches one instruction at a time over a valid/ready read channel. It
// presents the instruction to the IDU through a valid/ready handshake. It
// then waits for the next PC from the WBU before it starts the next fetch.
//
// Ports
//   clk, rst          core clock; asynchronous active-low reset
//   ifu_ar*           read request channel (address = pc)
//   ifu_r*            read data channel (rresp != 0 marks a bus error)
//   out_*             instruction handed to the IDU, with its PC and fault flag
//   wb_valid/wb_dnpc  next PC from the WBU, consumed only in EXEC
//   pc                current architectural PC
//   fetch_cnt         number of instructions delivered to the IDU (wraps)
module ysyx_25020047_ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_arvalid,
  output logic [31:0] ifu_araddr,
  input  logic        ifu_arready,
  input  logic        ifu_rvalid,
  input  logic [31:0] ifu_rdata,
  input  logic [1:0]  ifu_rresp,
  output logic        ifu_rready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_err,
  input  logic        wb_valid,
  input  logic [31:0] wb_dnpc,
  output logic [31:0] pc,
  output logic [31:0] fetch_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_EXEC = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] inst_q, inst_d;
  logic        err_q, err_d;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fetch_cnt_d = fetch_cnt_q;
    inst_d      = inst_q;
    err_d       = err_q;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (ifu_arready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ifu_rvalid) begin
          inst_d  = ifu_rdata;
          err_d   = (ifu_rresp != 2'b00);
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        // Error fetches are counted like any other delivery.
        if (out_ready) begin
          fetch_cnt_d = fetch_cnt_q + 32'd1;
          state_d     = S_EXEC;
        end
      end
      S_EXEC: begin
        if (wb_valid) begin
          pc_d = wb_dnpc;
          if (wb_dnpc[1:0] == 2'b00) begin
            state_d = S_REQ;
          end else begin
            // A misaligned target never reaches the bus. It is reported as
            // a faulting instruction so the IDU/EXU can raise the trap.
            inst_d  = 32'd0;
            err_d   = 1'b1;
            state_d = S_HOLD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      fetch_cnt_q <= 32'd0;
      inst_q      <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fetch_cnt_q <= fetch_cnt_d;
      inst_q      <= inst_d;
      err_q       <= err_d;
    end
  end

  // Handshake outputs decode only the registered state, so they have no
  // combinational path from any input.
  assign ifu_arvalid = (state_q == S_REQ);
  assign ifu_rready  = (state_q == S_WAIT);
  assign out_valid   = (state_q == S_HOLD);
  assign ifu_araddr  = pc_q;
  assign out_pc      = pc_q;
  assign out_inst    = inst_q;
  assign out_err     = err_q;
  assign pc          = pc_q;
  assign fetch_cnt   = fetch_cnt_q;

endmodule

// File: tb/tb_ysyx_25020047_ifu_fetch.sv
module tb_ysyx_25020047_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ifu_arvalid;
  logic [31:0] ifu_araddr;
  logic        ifu_arready = 1'b0;
  logic        ifu_rvalid = 1'b0;
  logic [31:0] ifu_rdata = 32'd0;
  logic [1:0]  ifu_rresp = 2'b00;
  logic        ifu_rready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_err;
  logic        wb_valid = 1'b0;
  logic [31:0] wb_dnpc = 32'd0;
  logic [31:0] pc;
  logic [31:0] fetch_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int ar_hs  = 0;
  logic force_cnt = 1'b0;

  ysyx_25020047_ifu_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arready(ifu_arready),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp),
    .ifu_rready(ifu_rready),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .out_err(out_err),
    .wb_valid(wb_valid), .wb_dnpc(wb_dnpc),
    .pc(pc), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: what the unit is currently waiting for, plus the
  // architectural values the spec says it must expose.
  localparam int W_BOOT = 0;  // just out of reset
  localparam int W_MEM_ACCEPT = 1;  // request posted, waiting for arready
  localparam int W_MEM_DATA = 2;  // waiting for rvalid
  localparam int W_IDU = 3;  // instruction offered to IDU
  localparam int W_NEXT_PC = 4;  // waiting for WBU dnpc

  int          m_wait;
  logic [31:0] m_pc, m_cnt, m_inst;
  logic        m_err;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_wait <= W_BOOT;
      m_pc   <= RST_PC;
      m_cnt  <= 32'd0;
      m_inst <= 32'd0;
      m_err  <= 1'b0;
    end else begin
      if (force_cnt) m_cnt <= 32'hFFFF_FFFF;
      if (m_wait == W_BOOT) m_wait <= W_MEM_ACCEPT;
      else if (m_wait == W_MEM_ACCEPT && ifu_arready) m_wait <= W_MEM_DATA;
      else if (m_wait == W_MEM_DATA && ifu_rvalid) begin
        m_inst <= ifu_rdata;
        m_err  <= (ifu_rresp != 2'b00);
        m_wait <= W_IDU;
      end else if (m_wait == W_IDU && out_ready) begin
        m_cnt  <= m_cnt + 32'd1;
        m_wait <= W_NEXT_PC;
      end else if (m_wait == W_NEXT_PC && wb_valid) begin
        m_pc <= wb_dnpc;
        if (wb_dnpc % 4 == 0) m_wait <= W_MEM_ACCEPT;
        else begin
          m_inst <= 32'd0;
          m_err  <= 1'b1;
          m_wait <= W_IDU;
        end
      end
    end
  end

  always @(posedge clk) if (rst && ifu_arvalid && ifu_arready) ar_hs <= ar_hs + 1;

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    chk("arvalid",   {31'd0, ifu_arvalid}, {31'd0, m_wait == W_MEM_ACCEPT});
    chk("rready",    {31'd0, ifu_rready},  {31'd0, m_wait == W_MEM_DATA});
    chk("out_valid", {31'd0, out_valid},   {31'd0, m_wait == W_IDU});
    chk("araddr",    ifu_araddr, m_pc);
    chk("out_pc",    out_pc, m_pc);
    chk("pc",        pc, m_pc);
    chk("fetch_cnt", fetch_cnt, m_cnt);
    if (m_wait == W_IDU || !rst) begin
      chk("out_inst", out_inst, m_inst);
      chk("out_err",  {31'd0, out_err}, {31'd0, m_err});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    logic [31:0] r;

    // Reset values.
    repeat (3) tick();
    chk("rst_arvalid", {31'd0, ifu_arvalid}, 32'd0);
    chk("rst_outvalid", {31'd0, out_valid}, 32'd0);
    chk("rst_araddr", ifu_araddr, 32'h8000_0000);
    chk("rst_cnt", fetch_cnt, 32'd0);

    // Best-case first fetch.
    rst = 1'b1; ifu_arready = 1'b1; ifu_rvalid = 1'b1;
    ifu_rdata = 32'h0000_0413; ifu_rresp = 2'b00; out_ready = 1'b1;
    tick();
    chk("c1_arvalid", {31'd0, ifu_arvalid}, 32'd1);
    chk("c1_araddr", ifu_araddr, 32'h8000_0000);
    tick();
    tick();
    chk("c3_outvalid", {31'd0, out_valid}, 32'd1);
    chk("c3_inst", out_inst, 32'h0000_0413);
    chk("c3_pc", out_pc, 32'h8000_0000);
    chk("c3_err", {31'd0, out_err}, 32'd0);
    tick();
    chk("c4_cnt", fetch_cnt, 32'd1);

    // Aligned next PC, then arready stall of 5 cycles.
    ifu_arready = 1'b0; ifu_rvalid = 1'b0; out_ready = 1'b0;
    wb_valid = 1'b1; wb_dnpc = 32'h8000_0010;
    tick();
    wb_valid = 1'b0;
    hs0 = ar_hs;
    for (int i = 0; i < 6; i++) begin
      chk("stall_arvalid", {31'd0, ifu_arvalid}, 32'd1);
      chk("stall_araddr", ifu_araddr, 32'h8000_0010);
      if (i == 5) ifu_arready = 1'b1;
      tick();
    end
    ifu_arready = 1'b0;
    chk("stall_rready", {31'd0, ifu_rready}, 32'd1);

    // Error response, then IDU back-pressure with ignored wb_valid pulses.
    ifu_rvalid = 1'b1; ifu_rdata = 32'hDEAD_BEEF; ifu_rresp = 2'b10;
    tick();
    ifu_rvalid = 1'b0; ifu_rresp = 2'b00;
    chk("one_accept", ar_hs - hs0, 32'd1);
    wb_dnpc = 32'h8000_0040;
    for (int i = 0; i < 4; i++) begin
      wb_valid = (i == 1 || i == 2);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_inst", out_inst, 32'hDEAD_BEEF);
      chk("hold_err", {31'd0, out_err}, 32'd1);
      chk("hold_pc", pc, 32'h8000_0010);
      tick();
    end
    wb_valid = 1'b0; out_ready = 1'b1;
    chk("hold_valid_end", {31'd0, out_valid}, 32'd1);
    tick();
    out_ready = 1'b0;
    chk("err_cnt", fetch_cnt, 32'd2);

    // Misaligned next PC goes straight to the IDU as a fault.
    wb_valid = 1'b1; wb_dnpc = 32'h8000_0012;
    tick();
    wb_valid = 1'b0;
    chk("mis_arvalid", {31'd0, ifu_arvalid}, 32'd0);
    chk("mis_valid", {31'd0, out_valid}, 32'd1);
    chk("mis_err", {31'd0, out_err}, 32'd1);
    chk("mis_inst", out_inst, 32'd0);
    chk("mis_pc", out_pc, 32'h8000_0012);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("mis_cnt", fetch_cnt, 32'd3);

    // Randomized traffic, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      ifu_arready = ($urandom % 3) != 0;
      ifu_rvalid  = ($urandom % 3) != 0;
      ifu_rdata   = $urandom;
      ifu_rresp   = (($urandom % 6) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      out_ready   = ($urandom % 2) != 0;
      wb_valid    = ($urandom % 4) == 0;
      r = $urandom;
      wb_dnpc     = (($urandom % 5) == 0) ? r : {r[31:2], 2'b00};
      tick();
    end

    // Drive the unit to a request, then reset it mid-WAIT.
    ifu_arready = 1'b0; ifu_rvalid = 1'b1; ifu_rresp = 2'b00; out_ready = 1'b1;
    wb_valid = 1'b1; wb_dnpc = 32'h8000_0100;
    for (int i = 0; i < 12 && !ifu_arvalid; i++) tick();
    chk("reach_req", {31'd0, ifu_arvalid}, 32'd1);
    wb_valid = 1'b0; ifu_rvalid = 1'b0; out_ready = 1'b0; ifu_arready = 1'b1;
    tick();
    ifu_arready = 1'b0;
    chk("pre_rst_rready", {31'd0, ifu_rready}, 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("arst_pc", pc, 32'h8000_0000);
    chk("arst_rready", {31'd0, ifu_rready}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    ifu_rvalid = 1'b1; ifu_rdata = 32'hBAD0_BAD0;
    tick();
    chk("stale_arvalid", {31'd0, ifu_arvalid}, 32'd1);
    chk("stale_araddr", ifu_araddr, 32'h8000_0000);
    ifu_rvalid = 1'b0; ifu_arready = 1'b1;
    tick();
    ifu_arready = 1'b0; ifu_rvalid = 1'b1; ifu_rdata = 32'h0010_0073;
    tick();
    ifu_rvalid = 1'b0;
    chk("fresh_inst", out_inst, 32'h0010_0073);
    chk("fresh_pc", out_pc, 32'h8000_0000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("fresh_cnt", fetch_cnt, 32'd1);

    // Counter wrap.
    @(negedge clk);
    #1;
    force dut.fetch_cnt_q = 32'hFFFF_FFFF;
    force_cnt = 1'b1;
    @(posedge clk);
    #1;
    release dut.fetch_cnt_q;
    force_cnt = 1'b0;
    tick();
    chk("preload_cnt", fetch_cnt, 32'hFFFF_FFFF);
    wb_valid = 1'b1; wb_dnpc = 32'h8000_0020;
    ifu_arready = 1'b1; ifu_rvalid = 1'b1; ifu_rdata = 32'h0000_0013; out_ready = 1'b1;
    tick();
    wb_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("wrap_cnt", fetch_cnt, 32'd0);
    ifu_arready = 1'b0; ifu_rvalid = 1'b0; out_ready = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
